// File: rtl/step_ctrl.sv
// CPU run/step controller: debounces the step key, divides the clock into rate ticks and
// issues single-cycle CPU clock enables in free-run, single-step, burst and breakpoint modes.
module step_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int TICK_DIV  = 50000000,
  parameter int PC_W      = 16,
  parameter int CC_W      = 16
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            key_step_n_i,
  input  logic [1:0]      mode_i,
  input  logic [7:0]      burst_len_i,
  input  logic [PC_W-1:0] bp_addr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            cpu_en_o,
  output logic [CC_W-1:0] cc_o,
  output logic [1:0]      state_o,
  output logic            halted_o
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int TICK_W = $clog2(TICK_DIV);

  localparam logic [1:0] MODE_FREE  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_BP    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BURST = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  logic [1:0]        sync_q;
  logic              key_s;
  logic              db_q, db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              press_q, press_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [1:0]        mode_q;
  state_t            state_q, state_d;
  logic [7:0]        steps_q, steps_d;
  logic              cpu_en_q, cpu_en_d;
  logic [CC_W-1:0]   cc_q, cc_d;

  assign key_s = sync_q[1];

  // A level is accepted only after DB_CYCLES consecutive samples differing from the
  // accepted level; any sample equal to it restarts the count.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (key_s != db_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        db_d    = key_s;
        press_d = ~key_s;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  always_comb begin
    state_d  = state_q;
    steps_d  = steps_q;
    cpu_en_d = 1'b0;
    if (mode_i != mode_q) begin
      // A mode switch drops any pending press/tick and restarts from a clean state.
      state_d = (mode_i == MODE_FREE) ? ST_RUN : ST_IDLE;
      steps_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          case (mode_i)
            MODE_FREE:  state_d = ST_RUN;
            MODE_STEP:  cpu_en_d = press_q;
            MODE_BURST: begin
              if (press_q && (burst_len_i != 8'd0)) begin
                steps_d = burst_len_i;
                state_d = ST_BURST;
              end
            end
            default: begin
              if (press_q) state_d = ST_RUN;
            end
          endcase
        end
        ST_RUN: begin
          if (mode_i == MODE_FREE) begin
            cpu_en_d = tick;
          end else if (mode_i == MODE_BP) begin
            if (tick) begin
              if (pc_i == bp_addr_i) state_d = ST_HALT;
              else                   cpu_en_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BURST: begin
          if (mode_i != MODE_BURST) begin
            state_d = ST_IDLE;
            steps_d = '0;
          end else if (tick) begin
            cpu_en_d = 1'b1;
            steps_d  = steps_q - 8'd1;
            if (steps_q == 8'd1) state_d = ST_IDLE;
          end
        end
        default: begin
          // Resume steps past the breakpoint without comparing pc.
          if (press_q) begin
            cpu_en_d = 1'b1;
            state_d  = ST_RUN;
          end
        end
      endcase
    end
  end

  assign cc_d = cc_q + CC_W'(cpu_en_q);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q     <= 2'b11;
      db_q       <= 1'b1;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      tick_cnt_q <= '0;
      mode_q     <= MODE_FREE;
      state_q    <= ST_IDLE;
      steps_q    <= '0;
      cpu_en_q   <= 1'b0;
      cc_q       <= '0;
    end else begin
      sync_q     <= {sync_q[0], key_step_n_i};
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      tick_cnt_q <= tick_cnt_d;
      mode_q     <= mode_i;
      state_q    <= state_d;
      steps_q    <= steps_d;
      cpu_en_q   <= cpu_en_d;
      cc_q       <= cc_d;
    end
  end

  assign cpu_en_o = cpu_en_q;
  assign cc_o     = cc_q;
  assign state_o  = state_q;
  assign halted_o = (state_q == ST_HALT);

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with DB_CYCLES=4, TICK_DIV=8; a second small-counter
// instance exercises the clock-counter wrap.
module tb_step_ctrl;

  logic        clk;
  logic        rst;
  logic        key_n;
  logic [1:0]  mode;
  logic [7:0]  blen;
  logic [15:0] bp;
  logic [15:0] pc;
  logic        cpu_en;
  logic [15:0] cc;
  logic [1:0]  state;
  logic        halted;

  logic        w_rst;
  logic        w_key_n;
  logic [1:0]  w_mode;
  logic [7:0]  w_blen;
  logic [15:0] w_bp;
  logic [15:0] w_pc;
  logic        w_cpu_en;
  logic [3:0]  w_cc;
  logic [1:0]  w_state;
  logic        w_halted;

  int checks = 0;
  int errors = 0;
  int cyc, pulses, first_pos, last_pos;

  step_ctrl #(.DB_CYCLES(4), .TICK_DIV(8), .PC_W(16), .CC_W(16)) dut (
    .clock_i(clk), .reset_i(rst), .key_step_n_i(key_n), .mode_i(mode),
    .burst_len_i(blen), .bp_addr_i(bp), .pc_i(pc),
    .cpu_en_o(cpu_en), .cc_o(cc), .state_o(state), .halted_o(halted)
  );

  step_ctrl #(.DB_CYCLES(4), .TICK_DIV(8), .PC_W(16), .CC_W(4)) u_wrap (
    .clock_i(clk), .reset_i(w_rst), .key_step_n_i(w_key_n), .mode_i(w_mode),
    .burst_len_i(w_blen), .bp_addr_i(w_bp), .pc_i(w_pc),
    .cpu_en_o(w_cpu_en), .cc_o(w_cc), .state_o(w_state), .halted_o(w_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; samples cpu_en 1 ns after the edge and advances the modelled pc.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cpu_en === 1'b1) begin
        pulses++;
        if (first_pos == 0) first_pos = cyc;
        last_pos = cyc;
        pc = pc + 16'd4;
      end
    end
  endtask

  task automatic clear_count();
    cyc = 0; pulses = 0; first_pos = 0; last_pos = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_count();
  endtask

  task automatic press(input int hold, input int rel);
    key_n = 1'b0;
    step(hold);
    key_n = 1'b1;
    step(rel);
  endtask

  initial begin
    rst = 1'b1; key_n = 1'b1; mode = 2'b00; blen = 8'd0; bp = 16'h0; pc = 16'h0;
    w_rst = 1'b1; w_key_n = 1'b1; w_mode = 2'b00; w_blen = 8'd0; w_bp = 16'h0; w_pc = 16'h0;
    clear_count();

    // Reset values
    #12;
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_cc", 32'(cc), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    // Free-run: enables every 8 cycles starting at cycle 8
    do_reset();
    step(82);
    check("free_pulses", 32'(pulses), 32'd10);
    check("free_first", 32'(first_pos), 32'd8);
    check("free_last", 32'(last_pos), 32'd80);
    check("free_cc", 32'(cc), 32'd10);
    check("free_state", 32'(state), 32'd1);

    // Single-step with a bouncing key: one press, enable 7 cycles after the final edge
    mode = 2'b01;
    do_reset();
    step(4);
    clear_count();
    key_n = 1'b0; step(2);
    key_n = 1'b1; step(2);
    key_n = 1'b0;
    clear_count();
    step(20);
    check("bounce_pulses", 32'(pulses), 32'd1);
    check("bounce_pos", 32'(first_pos), 32'd7);
    key_n = 1'b1; step(12);

    // Single-step, three clean presses; ticks alone never enable
    do_reset();
    step(4);
    for (int i = 0; i < 3; i++) begin
      clear_count();
      press(12, 12);
      check($sformatf("step%0d_pulses", i), 32'(pulses), 32'd1);
      check($sformatf("step%0d_pos", i), 32'(first_pos), 32'd7);
    end
    check("step_cc", 32'(cc), 32'd3);
    check("step_state", 32'(state), 32'd0);

    // Burst of 5 with a second press mid-burst that must be ignored
    mode = 2'b10; blen = 8'd5;
    do_reset();
    key_n = 1'b0; step(12);
    key_n = 1'b1; step(8);
    check("burst_mid_state", 32'(state), 32'd2);
    key_n = 1'b0; step(12);
    key_n = 1'b1; step(68);
    check("burst_pulses", 32'(pulses), 32'd5);
    check("burst_end_state", 32'(state), 32'd0);
    check("burst_cc", 32'(cc), 32'd5);

    // Burst length zero: press does nothing
    blen = 8'd0;
    clear_count();
    press(12, 30);
    check("burst0_pulses", 32'(pulses), 32'd0);
    check("burst0_state", 32'(state), 32'd0);

    // Run to breakpoint 0x000C, pc advancing by 4 per enable
    mode = 2'b11; bp = 16'h000C; pc = 16'h0000;
    do_reset();
    press(12, 60);
    check("bp_pulses", 32'(pulses), 32'd3);
    check("bp_state", 32'(state), 32'd3);
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_pc", 32'(pc), 32'h000C);
    clear_count();
    press(12, 12);
    check("bp_resume_pos", 32'(first_pos), 32'd7);
    check("bp_resume_state", 32'(state), 32'd1);
    check("bp_resume_halted", 32'(halted), 32'd0);
    check("bp_pc_past", 32'(pc > 16'h000C), 32'd1);

    // Asynchronous reset in the middle of a burst, while an enable is active
    mode = 2'b10; blen = 8'd5;
    do_reset();
    key_n = 1'b0; step(12);
    key_n = 1'b1;
    for (int i = 0; i < 100 && pulses < 2; i++) step(1);
    check("midburst_reached", 32'(pulses), 32'd2);
    check("midburst_en_before", 32'(cpu_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midburst_rst_en", 32'(cpu_en), 32'd0);
    check("midburst_rst_cc", 32'(cc), 32'd0);
    check("midburst_rst_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_count();
    step(40);
    check("midburst_after_pulses", 32'(pulses), 32'd0);
    check("midburst_after_state", 32'(state), 32'd0);

    // Clock counter wrap on the 4-bit instance
    @(posedge clk); #1;
    w_rst = 1'b0;
    repeat (121) @(posedge clk);
    #1;
    check("wrap_cc_max", 32'(w_cc), 32'hF);
    repeat (8) @(posedge clk);
    #1;
    check("wrap_cc_zero", 32'(w_cc), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
